// File: rtl/alu_arbiter_pkg.sv
// Shared encodings and widths for the ALU arbiter and the alu datapath.
// Holds the one-hot operation codes, the arbiter state encoding and the request payload layout.
package alu_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned OP_WIDTH   = 5;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned CNT_WIDTH  = 16;

  // One-hot operation codes; the alu treats anything else as result = B.
  localparam logic [OP_WIDTH-1:0] OP_NONE = 5'b00000;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 5'b00001;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 5'b00010;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 5'b00100;
  localparam logic [OP_WIDTH-1:0] OP_NOT  = 5'b01000;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_WIDTH-1:0]   op;
  } req_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, on contention the
// requester that was not granted last wins.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_last_grant,
  output logic               o_grant_any_c,
  output logic               o_grant_idx_c,
  output logic [NUM_REQ-1:0] o_grant_c
);

  always_comb begin
    o_grant_any_c = |i_valid;
    o_grant_idx_c = 1'b0;
    o_grant_c     = '0;
    if (&i_valid) begin
      o_grant_idx_c = ~i_last_grant;
    end else begin
      o_grant_idx_c = i_valid[1];
    end
    if (o_grant_any_c) begin
      o_grant_c = idx_to_onehot(o_grant_idx_c);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external alu between two requesters: round-robin accept, issue to the
// alu, capture its registered result, then hand it back over a valid/ready response.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [NUM_REQ-1:0]            iReqValid,
  output logic [NUM_REQ-1:0]            oReqReady,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqOperandA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqOperandB,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   iReqOperation,
  output logic [DATA_WIDTH-1:0]         oAluOperandA,
  output logic [DATA_WIDTH-1:0]         oAluOperandB,
  output logic [OP_WIDTH-1:0]           oAluOperation,
  input  logic [DATA_WIDTH-1:0]         iAluResult,
  output logic [NUM_REQ-1:0]            oRespValid,
  input  logic [NUM_REQ-1:0]            iRespReady,
  output logic [DATA_WIDTH-1:0]         oRespResult,
  output logic                          oBusy,
  output logic [CNT_WIDTH-1:0]          oOpCount
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_result;
  logic [NUM_REQ-1:0]    r_resp_valid;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_op_count;

  logic                  w_grant_any;
  logic                  w_grant_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic                  w_accept;
  logic                  w_resp_done;
  req_t                  w_sel_req;
  logic [CNT_WIDTH-1:0]  w_op_count_nxt;

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid       (iReqValid),
    .i_last_grant  (r_last_grant),
    .o_grant_any_c (w_grant_any),
    .o_grant_idx_c (w_grant_idx),
    .o_grant_c     (w_grant)
  );

  // Payload slice of the requester currently winning arbitration.
  always_comb begin
    w_sel_req = '0;
    if (w_grant_idx) begin
      w_sel_req.a  = iReqOperandA[2*DATA_WIDTH-1:DATA_WIDTH];
      w_sel_req.b  = iReqOperandB[2*DATA_WIDTH-1:DATA_WIDTH];
      w_sel_req.op = iReqOperation[2*OP_WIDTH-1:OP_WIDTH];
    end else begin
      w_sel_req.a  = iReqOperandA[DATA_WIDTH-1:0];
      w_sel_req.b  = iReqOperandB[DATA_WIDTH-1:0];
      w_sel_req.op = iReqOperation[OP_WIDTH-1:0];
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_resp_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_ready = w_grant;
        if (w_grant_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (iRespReady[r_owner]) begin
          w_resp_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_op_count_nxt = r_op_count + CNT_WIDTH'(w_resp_done);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_alu_op     <= OP_NONE;
      r_result     <= '0;
      r_resp_valid <= '0;
      r_busy       <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_op_count <= w_op_count_nxt;
      // The operation code is presented to the alu only during the ISSUE cycle.
      r_alu_op   <= w_accept ? w_sel_req.op : OP_NONE;
      if (w_accept) begin
        r_op_a       <= w_sel_req.a;
        r_op_b       <= w_sel_req.b;
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      if (r_state == ST_WAIT) begin
        r_result <= iAluResult;
      end
      r_resp_valid <= (w_state_nxt == ST_RESP) ? idx_to_onehot(r_owner) : '0;
    end
  end

  assign oReqReady     = w_req_ready;
  assign oAluOperandA  = r_op_a;
  assign oAluOperandB  = r_op_b;
  assign oAluOperation = r_alu_op;
  assign oRespValid    = r_resp_valid;
  assign oRespResult   = r_result;
  assign oBusy         = r_busy;
  assign oOpCount      = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural one-cycle registered alu alongside it.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [1:0]  iReqValid;
  logic [1:0]  oReqReady;
  logic [31:0] iReqOperandA;
  logic [31:0] iReqOperandB;
  logic [9:0]  iReqOperation;
  logic [15:0] oAluOperandA;
  logic [15:0] oAluOperandB;
  logic [4:0]  oAluOperation;
  logic [15:0] iAluResult;
  logic [1:0]  oRespValid;
  logic [1:0]  iRespReady;
  logic [15:0] oRespResult;
  logic        oBusy;
  logic [15:0] oOpCount;

  alu_arbiter dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iReqValid     (iReqValid),
    .oReqReady     (oReqReady),
    .iReqOperandA  (iReqOperandA),
    .iReqOperandB  (iReqOperandB),
    .iReqOperation (iReqOperation),
    .oAluOperandA  (oAluOperandA),
    .oAluOperandB  (oAluOperandB),
    .oAluOperation (oAluOperation),
    .iAluResult    (iAluResult),
    .oRespValid    (oRespValid),
    .iRespReady    (iRespReady),
    .oRespResult   (oRespResult),
    .oBusy         (oBusy),
    .oOpCount      (oOpCount)
  );

  always #5 iClock = ~iClock;

  // Behavioural alu: result registered one cycle after the operation is presented.
  always @(posedge iClock) begin
    case (oAluOperation)
      5'b00001: iAluResult <= oAluOperandA + oAluOperandB;
      5'b00010: iAluResult <= oAluOperandA ^ oAluOperandB;
      5'b00100: iAluResult <= oAluOperandA | oAluOperandB;
      5'b01000: iAluResult <= ~oAluOperandA;
      5'b10000: iAluResult <= oAluOperandA & oAluOperandB;
      default:  iAluResult <= oAluOperandB;
    endcase
  end

  typedef struct {
    logic [1:0]  owner;
    logic [15:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  // Requester protocol and grant-shape assertions.
  logic [1:0]  p_pend = 2'b00;
  logic [31:0] p_a, p_b;
  logic [9:0]  p_op;
  always @(posedge iClock) begin
    if (!iReset) begin
      for (int i = 0; i < 2; i++) begin
        if (p_pend[i]) begin
          assert (iReqValid[i] &&
                  iReqOperandA[i*16 +: 16] == p_a[i*16 +: 16] &&
                  iReqOperandB[i*16 +: 16] == p_b[i*16 +: 16] &&
                  iReqOperation[i*5 +: 5] == p_op[i*5 +: 5])
            else $error("protocol: requester %0d changed before accept", i);
        end
      end
      assert ($onehot0(oReqReady)) else $error("oReqReady not one-hot: %b", oReqReady);
    end
    p_pend <= iReset ? 2'b00 : (iReqValid & ~oReqReady);
    p_a    <= iReqOperandA;
    p_b    <= iReqOperandB;
    p_op   <= iReqOperation;
  end

  task automatic tick();
    @(negedge iClock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op);
    if (idx == 0) begin
      iReqOperandA[15:0] = a; iReqOperandB[15:0] = b; iReqOperation[4:0] = op;
      iReqValid[0] = 1'b1;
    end else begin
      iReqOperandA[31:16] = a; iReqOperandB[31:16] = b; iReqOperation[9:5] = op;
      iReqValid[1] = 1'b1;
    end
  endtask

  task automatic clr_req(input int idx);
    iReqValid[idx] = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'b00;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (oReqReady != 2'b00) begin
        g  = oReqReady;
        ok = 1'b1;
        return;
      end
      @(negedge iClock);
    end
  endtask

  task automatic wait_resp(output logic [1:0] v, output logic [15:0] r, output bit ok);
    ok = 1'b0;
    v  = 2'b00;
    r  = 16'h0;
    for (int i = 0; i < 20; i++) begin
      if (oRespValid != 2'b00) begin
        v  = oRespValid;
        r  = oRespResult;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    tick();
    iReset        = 1'b1;
    iReqValid     = 2'b00;
    iRespReady    = 2'b00;
    iReqOperandA  = '0;
    iReqOperandB  = '0;
    iReqOperation = '0;
    tick();
    tick();
    iReset = 1'b0;
    sb.delete();
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (oReqReady !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", oReqReady); end
    n_vec++; if (oRespValid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid got %b want 00", oRespValid); end
    n_vec++; if (oAluOperation !== 5'b00000) begin n_err++; $display("FAIL reset_alu_op got %b want 00000", oAluOperation); end
    n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", oBusy); end
    n_vec++; if (oOpCount !== 16'h0000) begin n_err++; $display("FAIL reset_count got %h want 0000", oOpCount); end
    n_vec++; if (oRespResult !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", oRespResult); end
    n_vec++; if (oAluOperandA !== 16'h0000 || oAluOperandB !== 16'h0000) begin
      n_err++; $display("FAIL reset_operands got %h/%h want 0000/0000", oAluOperandA, oAluOperandB);
    end
  endtask

  task automatic test_single();
    exp_t e;
    iRespReady = 2'b01;
    set_req(0, 16'h1234, 16'h0011, 5'b00001);
    sb.push_back('{owner: 2'b01, res: 16'h1245});
    #1;
    n_vec++; if (oReqReady !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", oReqReady); end
    @(posedge iClock);
    tick();
    clr_req(0);
    n_vec++; if (oAluOperation !== 5'b00001) begin n_err++; $display("FAIL single_op_issue got %b want 00001", oAluOperation); end
    n_vec++; if (oAluOperandA !== 16'h1234 || oAluOperandB !== 16'h0011) begin
      n_err++; $display("FAIL single_operands got %h/%h want 1234/0011", oAluOperandA, oAluOperandB);
    end
    tick();
    n_vec++; if (oAluOperation !== 5'b00000) begin n_err++; $display("FAIL single_op_wait got %b want 00000", oAluOperation); end
    n_vec++; if (oRespValid !== 2'b00) begin n_err++; $display("FAIL single_resp_early got %b want 00", oRespValid); end
    tick();
    e = sb.pop_front();
    n_vec++; if (oRespValid !== e.owner) begin n_err++; $display("FAIL single_resp_valid got %b want %b", oRespValid, e.owner); end
    n_vec++; if (oRespResult !== e.res) begin n_err++; $display("FAIL single_resp_result got %h want %h", oRespResult, e.res); end
    exp_cnt++;
    tick();
    n_vec++; if (oOpCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL single_count got %h want %h", oOpCount, 16'(exp_cnt)); end
    n_vec++; if (oBusy !== 1'b0 || oRespValid !== 2'b00) begin
      n_err++; $display("FAIL single_done got busy=%b valid=%b want 0/00", oBusy, oRespValid);
    end
    iRespReady = 2'b00;
  endtask

  task automatic test_contention();
    int          order[5] = '{0, 1, 0, 1, 0};
    logic [1:0]  g, v;
    logic [15:0] r;
    bit          ok;
    exp_t        e;
    do_reset();
    iRespReady = 2'b11;
    set_req(0, 16'hFF00, 16'h0FF0, 5'b00010);
    set_req(1, 16'hFF00, 16'h0FF0, 5'b10000);
    foreach (order[k]) sb.push_back('{owner: (order[k] == 0) ? 2'b01 : 2'b10,
                                      res:   (order[k] == 0) ? 16'hF0F0 : 16'h0F00});
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      e = sb.pop_front();
      n_vec++; if (!ok || g !== e.owner) begin n_err++; $display("FAIL contention_grant%0d got %b want %b", k, g, e.owner); end
      @(posedge iClock);
      tick();
      if (k == 3) clr_req(1);
      if (k == 4) clr_req(0);
      wait_resp(v, r, ok);
      n_vec++; if (!ok || v !== e.owner || r !== e.res) begin
        n_err++; $display("FAIL contention_resp%0d got %b/%h want %b/%h", k, v, r, e.owner, e.res);
      end
      exp_cnt++;
      tick();
    end
    n_vec++; if (oOpCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL contention_count got %h want %h", oOpCount, 16'(exp_cnt)); end
    iRespReady = 2'b00;
  endtask

  task automatic test_wrap_illegal();
    logic [15:0] va[4]  = '{16'hFFFF, 16'h1234, 16'h5555, 16'h00FF};
    logic [15:0] vb[4]  = '{16'h0001, 16'hBEEF, 16'h00AA, 16'h0000};
    logic [4:0]  vop[4] = '{5'b00001, 5'b00011, 5'b00000, 5'b01000};
    logic [15:0] vex[4] = '{16'h0000, 16'hBEEF, 16'h00AA, 16'hFF00};
    logic [1:0]  g, v;
    logic [15:0] r;
    bit          ok;
    exp_t        e;
    iRespReady = 2'b11;
    for (int i = 0; i < 4; i++) begin
      set_req(i % 2, va[i], vb[i], vop[i]);
      sb.push_back('{owner: (i % 2 == 0) ? 2'b01 : 2'b10, res: vex[i]});
      wait_grant(g, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_grant%0d got timeout want grant", i); end
      @(posedge iClock);
      tick();
      clr_req(i % 2);
      n_vec++; if (oAluOperation !== vop[i]) begin n_err++; $display("FAIL wrap_op_fwd%0d got %b want %b", i, oAluOperation, vop[i]); end
      wait_resp(v, r, ok);
      e = sb.pop_front();
      n_vec++; if (!ok || v !== e.owner || r !== e.res) begin
        n_err++; $display("FAIL wrap_resp%0d got %b/%h want %b/%h", i, v, r, e.owner, e.res);
      end
      exp_cnt++;
      tick();
    end
    n_vec++; if (oOpCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL wrap_count got %h want %h", oOpCount, 16'(exp_cnt)); end
    iRespReady = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [1:0]  g, v;
    logic [15:0] r;
    bit          ok;
    exp_t        e;
    iRespReady = 2'b00;
    set_req(0, 16'h00F0, 16'h0F00, 5'b00100);
    sb.push_back('{owner: 2'b01, res: 16'h0FF0});
    wait_grant(g, ok);
    @(posedge iClock);
    tick();
    clr_req(0);
    wait_resp(v, r, ok);
    e = sb.pop_front();
    n_vec++; if (!ok || v !== e.owner || r !== e.res) begin
      n_err++; $display("FAIL bp_resp got %b/%h want %b/%h", v, r, e.owner, e.res);
    end
    set_req(1, 16'h3C3C, 16'h0000, 5'b01000);
    sb.push_back('{owner: 2'b10, res: 16'hC3C3});
    for (int c = 0; c < 10; c++) begin
      iRespReady = (c % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      n_vec++; if (oRespValid !== 2'b01 || oRespResult !== 16'h0FF0) begin
        n_err++; $display("FAIL bp_hold%0d got %b/%h want 01/0ff0", c, oRespValid, oRespResult);
      end
      n_vec++; if (oReqReady !== 2'b00) begin n_err++; $display("FAIL bp_ready%0d got %b want 00", c, oReqReady); end
      tick();
    end
    iRespReady = 2'b01;
    @(posedge iClock);
    exp_cnt++;
    tick();
    n_vec++; if (oReqReady !== 2'b10) begin n_err++; $display("FAIL bp_next_grant got %b want 10", oReqReady); end
    n_vec++; if (oOpCount !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_count got %h want %h", oOpCount, 16'(exp_cnt)); end
    @(posedge iClock);
    tick();
    clr_req(1);
    iRespReady = 2'b11;
    wait_resp(v, r, ok);
    e = sb.pop_front();
    n_vec++; if (!ok || v !== e.owner || r !== e.res) begin
      n_err++; $display("FAIL bp_resp2 got %b/%h want %b/%h", v, r, e.owner, e.res);
    end
    exp_cnt++;
    tick();
    iRespReady = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    bit         ok;
    set_req(0, 16'h0001, 16'h0002, 5'b00001);
    sb.push_back('{owner: 2'b01, res: 16'h0003});
    wait_grant(g, ok);
    @(posedge iClock);
    tick();
    clr_req(0);
    tick();
    iReset = 1'b1;
    #1;
    sb.delete();
    exp_cnt = 0;
    n_vec++; if (oBusy !== 1'b0 || oAluOperation !== 5'b00000) begin
      n_err++; $display("FAIL midrst_busy_op got %b/%b want 0/00000", oBusy, oAluOperation);
    end
    n_vec++; if (oRespValid !== 2'b00 || oReqReady !== 2'b00) begin
      n_err++; $display("FAIL midrst_valid_ready got %b/%b want 00/00", oRespValid, oReqReady);
    end
    n_vec++; if (oOpCount !== 16'h0000 || oRespResult !== 16'h0000) begin
      n_err++; $display("FAIL midrst_count_result got %h/%h want 0000/0000", oOpCount, oRespResult);
    end
    tick();
    iReset = 1'b0;
    iRespReady = 2'b01;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++; if (oRespValid !== 2'b00) begin n_err++; $display("FAIL midrst_ghost%0d got %b want 00", c, oRespValid); end
    end
    n_vec++; if (oOpCount !== 16'h0000) begin n_err++; $display("FAIL midrst_count got %h want 0000", oOpCount); end
    iRespReady = 2'b00;
    test_single();
  endtask

  task automatic test_count_wrap();
    logic [1:0]  g, v;
    logic [15:0] r;
    bit          ok;
    exp_t        e;
    force dut.r_op_count = 16'hFFFF;
    tick();
    release dut.r_op_count;
    tick();
    n_vec++; if (oOpCount !== 16'hFFFF) begin n_err++; $display("FAIL wrapcnt_preload got %h want ffff", oOpCount); end
    iRespReady = 2'b11;
    set_req(1, 16'h0007, 16'h0008, 5'b00001);
    sb.push_back('{owner: 2'b10, res: 16'h000F});
    wait_grant(g, ok);
    @(posedge iClock);
    tick();
    clr_req(1);
    wait_resp(v, r, ok);
    e = sb.pop_front();
    n_vec++; if (!ok || v !== e.owner || r !== e.res) begin
      n_err++; $display("FAIL wrapcnt_resp got %b/%h want %b/%h", v, r, e.owner, e.res);
    end
    tick();
    n_vec++; if (oOpCount !== 16'h0000) begin n_err++; $display("FAIL wrapcnt_count got %h want 0000", oOpCount); end
    iRespReady = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    iReset        = 1'b1;
    iReqValid     = 2'b00;
    iRespReady    = 2'b00;
    iReqOperandA  = '0;
    iReqOperandB  = '0;
    iReqOperation = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap_illegal();
    test_backpressure();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
